// File: rtl/fetch_decode.sv
// fetch_decode: instruction sequencer in front of the mini-CPU execute unit.
// Fetches 16-bit words from instruction memory, decodes IDEN/OPCODE, fetches
// the operand (data memory or immediate), strobes START for one cycle and, for
// store instructions, writes the execute unit's STORE_DATA back to data memory.
//
// State table:
//   S_IDLE       | waiting for RUN after reset
//   S_FETCH      | IMEM_REQ held until IMEM_ACK; IR captured on ACK
//   S_DECODE     | fields latched, PC advanced, branch on IDEN
//   S_OPERAND_RD | DMEM read held until DMEM_ACK; OPERAND captured on ACK
//   S_EXEC       | START high for exactly this cycle
//   S_STORE_WAIT | execute unit settles STORE_DATA
//   S_STORE      | DMEM write held until DMEM_ACK
//   S_HALT       | HALTED high; RUN restarts at START_PC
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   RUN                      start / restart request
//   IMEM_REQ/ADDR/RDATA/ACK  instruction memory handshake
//   DMEM_REQ/WE/ADDR/WDATA/RDATA/ACK  data memory handshake
//   STORE_DATA               execute unit store result
//   START, IDEN, OPCODE, OPERAND  execute unit command
//   PC, BUSY, HALTED         status
module fetch_decode #(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] START_PC = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RUN,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic [15:0]       IMEM_RDATA,
    input  logic              IMEM_ACK,
    output logic              DMEM_REQ,
    output logic              DMEM_WE,
    output logic [ADDR_W-1:0] DMEM_ADDR,
    output logic [15:0]       DMEM_WDATA,
    input  logic [15:0]       DMEM_RDATA,
    input  logic              DMEM_ACK,
    input  logic [15:0]       STORE_DATA,
    output logic              START,
    output logic [1:0]        IDEN,
    output logic [3:0]        OPCODE,
    output logic [15:0]       OPERAND,
    output logic [ADDR_W-1:0] PC,
    output logic              BUSY,
    output logic              HALTED
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPERAND_RD,
        S_EXEC,
        S_STORE_WAIT,
        S_STORE,
        S_HALT
    } state_t;

    state_t      state;
    logic [15:0] ir;

    logic [1:0]        ir_iden;
    logic [3:0]        ir_opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic              needs_mem;
    logic              exec_is_store;

    assign ir_iden   = ir[15:14];
    assign ir_opcode = ir[13:10];
    assign ir_addr   = ir[ADDR_W-1:0];

    // ALU-style opcodes that take their operand from data memory
    assign needs_mem = (ir_opcode <= 4'd5) || (ir_opcode == 4'd8);

    // Uses the latched fields, which are the current instruction during EXEC
    assign exec_is_store = (IDEN == 2'b01) && (OPCODE == 4'hF);

    // Address outputs follow PC/IR directly; both are frozen while a request is open
    assign IMEM_ADDR = PC;
    assign DMEM_ADDR = ir_addr;

    generate
        if (ADDR_W < 10) begin : g_unused
            logic unused_ir_bits;
            assign unused_ir_bits = ^ir[9:ADDR_W];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            ir         <= '0;
            PC         <= START_PC;
            IDEN       <= '0;
            OPCODE     <= '0;
            OPERAND    <= '0;
            DMEM_WDATA <= '0;
            IMEM_REQ   <= 1'b0;
            DMEM_REQ   <= 1'b0;
            DMEM_WE    <= 1'b0;
            START      <= 1'b0;
            BUSY       <= 1'b0;
            HALTED     <= 1'b0;
        end else begin
            START <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (RUN) begin
                        IMEM_REQ <= 1'b1;
                        BUSY     <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (IMEM_ACK) begin
                        ir       <= IMEM_RDATA;
                        IMEM_REQ <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    IDEN   <= ir_iden;
                    OPCODE <= ir_opcode;
                    PC     <= PC + 1'b1;
                    case (ir_iden)
                        2'b00: begin
                            OPERAND <= {{(16-ADDR_W){1'b0}}, ir_addr};
                            START   <= 1'b1;
                            state   <= S_EXEC;
                        end
                        2'b01: begin
                            if (needs_mem) begin
                                DMEM_REQ <= 1'b1;
                                DMEM_WE  <= 1'b0;
                                state    <= S_OPERAND_RD;
                            end else begin
                                START <= 1'b1;
                                state <= S_EXEC;
                            end
                        end
                        2'b10: begin
                            // later assignment overrides the increment above
                            PC       <= ir_addr;
                            IMEM_REQ <= 1'b1;
                            state    <= S_FETCH;
                        end
                        default: begin
                            BUSY   <= 1'b0;
                            HALTED <= 1'b1;
                            state  <= S_HALT;
                        end
                    endcase
                end
                S_OPERAND_RD: begin
                    if (DMEM_ACK) begin
                        OPERAND  <= DMEM_RDATA;
                        DMEM_REQ <= 1'b0;
                        START    <= 1'b1;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_is_store) begin
                        state <= S_STORE_WAIT;
                    end else begin
                        IMEM_REQ <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_STORE_WAIT: begin
                    // single capture; STORE_DATA is only guaranteed this cycle
                    DMEM_WDATA <= STORE_DATA;
                    DMEM_REQ   <= 1'b1;
                    DMEM_WE    <= 1'b1;
                    state      <= S_STORE;
                end
                S_STORE: begin
                    if (DMEM_ACK) begin
                        DMEM_REQ <= 1'b0;
                        DMEM_WE  <= 1'b0;
                        IMEM_REQ <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (RUN) begin
                        PC       <= START_PC;
                        HALTED   <= 1'b0;
                        BUSY     <= 1'b1;
                        IMEM_REQ <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode.sv
// Testbench for fetch_decode: memory responders with programmable wait states,
// a toy execute unit for STORE_DATA, and an instruction-level reference model
// that predicts START events, data writes, fetch addresses and halt timing.
`timescale 1ns/1ns
module tb_fetch_decode;

    localparam int AW = 8;

    logic          CLK = 1'b0;
    logic          RST, RUN;
    logic          IMEM_REQ, IMEM_ACK;
    logic [AW-1:0] IMEM_ADDR;
    logic [15:0]   IMEM_RDATA;
    logic          DMEM_REQ, DMEM_WE, DMEM_ACK;
    logic [AW-1:0] DMEM_ADDR;
    logic [15:0]   DMEM_WDATA, DMEM_RDATA, STORE_DATA;
    logic          START, BUSY, HALTED;
    logic [1:0]    IDEN;
    logic [3:0]    OPCODE;
    logic [15:0]   OPERAND;
    logic [AW-1:0] PC;

    fetch_decode #(.ADDR_W(AW), .START_PC(8'h00)) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA), .IMEM_ACK(IMEM_ACK),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
        .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK), .STORE_DATA(STORE_DATA),
        .START(START), .IDEN(IDEN), .OPCODE(OPCODE), .OPERAND(OPERAND),
        .PC(PC), .BUSY(BUSY), .HALTED(HALTED)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] cyc;
        logic [1:0]  iden;
        logic [3:0]  opc;
        logic [15:0] opnd;
        logic [7:0]  pc;
    } start_t;

    typedef struct packed {
        logic [15:0] cyc;
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic [15:0] imem [256];
    logic [15:0] dmem [256];
    int          imem_dly [64];
    int          dmem_dly [64];
    logic [15:0] store_xor;
    logic        mem_auto;

    int   imem_idx, dmem_idx, imem_cnt, dmem_cnt, hold_err, halt_cyc;
    time  t0;
    start_t     start_q[$], exp_start_q[$];
    wr_t        wr_q[$],    exp_wr_q[$];
    logic [7:0] fetch_q[$], exp_fetch_q[$];
    int         exp_halt_cyc;
    logic [7:0] exp_pc;

    int n_checks, n_pass;

    // memory responders, execute-unit stand-in and trace recorder
    initial begin
        logic p_ireq, p_iack, p_dreq, p_dack, p_start, p_we;
        logic [7:0]  p_iaddr, p_daddr;
        logic [15:0] p_wdata;
        int cyc;
        p_ireq = 0; p_iack = 0; p_dreq = 0; p_dack = 0; p_start = 0; p_we = 0;
        p_iaddr = 0; p_daddr = 0; p_wdata = 0;
        forever begin
            @(negedge CLK);
            cyc = int'(($time - t0) / 10);
            if (!RST) begin
                if (p_ireq && !p_iack && (!IMEM_REQ || IMEM_ADDR != p_iaddr)) hold_err++;
                if (p_dreq && !p_dack && (!DMEM_REQ || DMEM_ADDR != p_daddr ||
                    DMEM_WE != p_we || DMEM_WDATA != p_wdata)) hold_err++;
                if (p_ireq && p_iack) begin
                    if (IMEM_REQ) hold_err++;
                    imem_idx++; imem_cnt = 0;
                end
                if (p_dreq && p_dack) begin
                    if (DMEM_REQ) hold_err++;
                    dmem_idx++; dmem_cnt = 0;
                end
                if (START && p_start) hold_err++;
            end
            if (IMEM_REQ && !p_ireq) fetch_q.push_back(IMEM_ADDR);
            if (START) start_q.push_back({16'(cyc), IDEN, OPCODE, OPERAND, PC});
            if (HALTED && halt_cyc < 0) halt_cyc = cyc;
            if (p_start) STORE_DATA = store_xor ^ OPERAND;
            else         STORE_DATA = 16'($urandom);
            if (mem_auto) begin
                IMEM_ACK = 1'b0;
                DMEM_ACK = 1'b0;
                if (IMEM_REQ) begin
                    if (imem_cnt >= imem_dly[imem_idx % 64]) begin
                        IMEM_ACK   = 1'b1;
                        IMEM_RDATA = imem[IMEM_ADDR];
                    end else begin
                        imem_cnt++;
                        IMEM_RDATA = 16'($urandom);
                    end
                end
                if (DMEM_REQ) begin
                    if (dmem_cnt >= dmem_dly[dmem_idx % 64]) begin
                        DMEM_ACK = 1'b1;
                        if (DMEM_WE) begin
                            dmem[DMEM_ADDR] = DMEM_WDATA;
                            wr_q.push_back({16'(cyc), DMEM_ADDR, DMEM_WDATA});
                        end else begin
                            DMEM_RDATA = dmem[DMEM_ADDR];
                        end
                    end else begin
                        dmem_cnt++;
                        DMEM_RDATA = 16'($urandom);
                    end
                end
            end
            p_ireq = IMEM_REQ; p_iack = IMEM_ACK; p_iaddr = IMEM_ADDR;
            p_dreq = DMEM_REQ; p_dack = DMEM_ACK; p_daddr = DMEM_ADDR;
            p_we = DMEM_WE; p_wdata = DMEM_WDATA; p_start = START;
        end
    end

    // Instruction-level model: each instruction costs fetch (1+waits), decode 1,
    // then an optional operand read (1+waits), exec 1, store wait 1, store (1+waits).
    task automatic model_run();
        logic [7:0]  pc;
        logic [15:0] opnd, ins;
        logic [15:0] md [256];
        int t, ii, di;
        pc = 8'h00; opnd = 16'h0; t = 0; ii = 0; di = 0;
        for (int a = 0; a < 256; a++) md[a] = dmem[a];
        exp_start_q.delete(); exp_wr_q.delete(); exp_fetch_q.delete();
        exp_halt_cyc = -1; exp_pc = 8'h00;
        for (int n = 0; n < 300; n++) begin
            ins = imem[pc];
            exp_fetch_q.push_back(pc);
            t = t + 1 + imem_dly[ii % 64]; ii++;
            t = t + 1;
            pc = pc + 8'd1;
            if (ins[15:14] == 2'd2) begin
                pc = ins[7:0];
            end else if (ins[15:14] == 2'd3) begin
                exp_halt_cyc = t + 1;
                exp_pc = pc;
                break;
            end else begin
                if (ins[15:14] == 2'd0) begin
                    opnd = {8'h00, ins[7:0]};
                end else if (ins[13:10] <= 4'd5 || ins[13:10] == 4'd8) begin
                    t = t + 1 + dmem_dly[di % 64]; di++;
                    opnd = md[ins[7:0]];
                end
                t = t + 1;
                exp_start_q.push_back({16'(t), ins[15:14], ins[13:10], opnd, pc});
                if (ins[15:14] == 2'd1 && ins[13:10] == 4'hF) begin
                    t = t + 1;
                    t = t + 1 + dmem_dly[di % 64]; di++;
                    md[ins[7:0]] = store_xor ^ opnd;
                    exp_wr_q.push_back({16'(t), ins[7:0], store_xor ^ opnd});
                end
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK); #1;
        RST = 1'b1; RUN = 1'b0; mem_auto = 1'b1;
        @(negedge CLK); #1;
        @(negedge CLK); #1;
        RST = 1'b0;
        imem_idx = 0; dmem_idx = 0; imem_cnt = 0; dmem_cnt = 0;
        hold_err = 0; halt_cyc = -1;
        start_q.delete(); wr_q.delete(); fetch_q.delete();
    endtask

    task automatic pulse_run();
        @(negedge CLK); #1;
        RUN = 1'b1; t0 = $time - 1;
        @(negedge CLK); #1;
        RUN = 1'b0;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) begin
            imem[a] = 16'hC000;
            dmem[a] = 16'($urandom);
        end
        for (int k = 0; k < 64; k++) begin
            imem_dly[k] = 0;
            dmem_dly[k] = 0;
        end
        store_xor = 16'h5A3C;
    endtask

    // Runs the loaded program to HALT and compares the whole trace against the model.
    task automatic run_program(input string name, input int max_cyc);
        int k;
        model_run();
        apply_reset();
        pulse_run();
        k = 0;
        while (!HALTED && k < max_cyc) begin
            @(negedge CLK); k++;
        end
        #1;
        n_checks++;
        if (HALTED !== 1'b1) $display("FAIL %s halted: got %b want 1 (timeout %0d cycles)", name, HALTED, max_cyc);
        else n_pass++;
        n_checks++;
        if (halt_cyc != exp_halt_cyc) $display("FAIL %s halt_cycle: got %0d want %0d", name, halt_cyc, exp_halt_cyc);
        else n_pass++;
        n_checks++;
        if (PC !== exp_pc || BUSY !== 1'b0) $display("FAIL %s final_pc/busy: got %h/%b want %h/0", name, PC, BUSY, exp_pc);
        else n_pass++;
        n_checks++;
        if (start_q.size() != exp_start_q.size())
            $display("FAIL %s start_count: got %0d want %0d", name, start_q.size(), exp_start_q.size());
        else n_pass++;
        for (int i = 0; i < start_q.size() && i < exp_start_q.size(); i++) begin
            n_checks++;
            if (start_q[i] !== exp_start_q[i])
                $display("FAIL %s start[%0d] {cyc,iden,opc,opnd,pc}: got %h want %h", name, i, start_q[i], exp_start_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (wr_q.size() != exp_wr_q.size())
            $display("FAIL %s write_count: got %0d want %0d", name, wr_q.size(), exp_wr_q.size());
        else n_pass++;
        for (int i = 0; i < wr_q.size() && i < exp_wr_q.size(); i++) begin
            n_checks++;
            if (wr_q[i] !== exp_wr_q[i])
                $display("FAIL %s write[%0d] {cyc,addr,data}: got %h want %h", name, i, wr_q[i], exp_wr_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (fetch_q != exp_fetch_q)
            $display("FAIL %s fetch_addrs: got %0d fetches want %0d", name, fetch_q.size(), exp_fetch_q.size());
        else n_pass++;
        n_checks++;
        if (hold_err != 0) $display("FAIL %s handshake_violations: got %0d want 0", name, hold_err);
        else n_pass++;
    endtask

    task automatic test_reset();
        clear_mem();
        apply_reset();
        #1;
        n_checks++;
        if ({IMEM_REQ, DMEM_REQ, DMEM_WE, START, BUSY, HALTED} !== 6'b0)
            $display("FAIL reset_strobes: got %b want 000000", {IMEM_REQ, DMEM_REQ, DMEM_WE, START, BUSY, HALTED});
        else n_pass++;
        n_checks++;
        if ({PC, IDEN, OPCODE, OPERAND, DMEM_WDATA} !== '0)
            $display("FAIL reset_regs: got pc=%h iden=%b opc=%h opnd=%h wdata=%h want all 0",
                     PC, IDEN, OPCODE, OPERAND, DMEM_WDATA);
        else n_pass++;
        // RUN is needed to leave IDLE
        repeat (3) @(negedge CLK);
        #1;
        n_checks++;
        if (IMEM_REQ !== 1'b0 || BUSY !== 1'b0) $display("FAIL idle_without_run: got req=%b busy=%b want 0/0", IMEM_REQ, BUSY);
        else n_pass++;
    endtask

    task automatic test_mem_operand();
        clear_mem();
        imem[0] = 16'h4005;
        dmem[5] = 16'h1234;
        run_program("mem_operand", 50);
        n_checks++;
        if (start_q.size() < 1 || start_q[0] !== {16'd4, 2'b01, 4'h0, 16'h1234, 8'h01})
            $display("FAIL mem_operand_start: got %0d starts, first %h want %h", start_q.size(),
                     (start_q.size() > 0) ? start_q[0] : start_t'(0), {16'd4, 2'b01, 4'h0, 16'h1234, 8'h01});
        else n_pass++;
    endtask

    task automatic test_immediate();
        clear_mem();
        imem[0] = 16'h002A;
        run_program("immediate", 50);
        n_checks++;
        if (start_q.size() < 1 || start_q[0].cyc !== 16'd3 || start_q[0].opnd !== 16'h002A)
            $display("FAIL immediate_start: got %0d starts, first %h want cyc 3 opnd 002a", start_q.size(),
                     (start_q.size() > 0) ? start_q[0] : start_t'(0));
        else n_pass++;
    endtask

    task automatic test_store();
        clear_mem();
        imem[0] = 16'h7C09;
        store_xor = 16'hBEEF;   // operand is 0 after reset, so STORE_DATA = BEEF
        run_program("store", 50);
        n_checks++;
        if (wr_q.size() != 1 || wr_q[0].addr !== 8'h09 || wr_q[0].data !== 16'hBEEF)
            $display("FAIL store_write: got %0d writes, first %h want addr 09 data beef", wr_q.size(),
                     (wr_q.size() > 0) ? wr_q[0] : wr_t'(0));
        else n_pass++;
    endtask

    task automatic test_wait_states();
        clear_mem();
        imem[0] = 16'h4005;
        dmem[5] = 16'h1234;
        imem_dly[0] = 3;
        dmem_dly[0] = 2;
        run_program("wait_states", 60);
        n_checks++;
        if (start_q.size() < 1 || start_q[0].cyc !== 16'd9)
            $display("FAIL wait_states_start_cycle: got %0d starts, first cyc %0d want 9", start_q.size(),
                     (start_q.size() > 0) ? start_q[0].cyc : 16'hFFFF);
        else n_pass++;
    endtask

    task automatic test_jump_halt_restart();
        clear_mem();
        imem[0]     = 16'h8010;
        imem[8'h10] = 16'hC000;
        imem[1]     = 16'h4001;
        run_program("jump_halt", 50);
        @(negedge CLK); #1;
        RUN = 1'b1;
        @(negedge CLK); #1;
        RUN = 1'b0;
        n_checks++;
        if (IMEM_REQ !== 1'b1 || PC !== 8'h00 || HALTED !== 1'b0 || BUSY !== 1'b1)
            $display("FAIL restart: got req=%b pc=%h halted=%b busy=%b want 1/00/0/1", IMEM_REQ, PC, HALTED, BUSY);
        else n_pass++;
    endtask

    task automatic test_pc_wrap();
        clear_mem();
        imem[0]     = 16'h80FE;
        imem[8'hFE] = 16'h0033;
        imem[8'hFF] = 16'hC000;
        run_program("pc_wrap", 60);
    endtask

    task automatic test_self_jump();
        int bad;
        clear_mem();
        imem[0] = 16'h8000;
        apply_reset();
        pulse_run();
        repeat (40) @(negedge CLK);
        #1;
        bad = 0;
        foreach (fetch_q[i]) if (fetch_q[i] !== 8'h00) bad++;
        n_checks++;
        if (start_q.size() != 0 || HALTED !== 1'b0 || BUSY !== 1'b1)
            $display("FAIL self_jump: got starts=%0d halted=%b busy=%b want 0/0/1", start_q.size(), HALTED, BUSY);
        else n_pass++;
        n_checks++;
        if (fetch_q.size() < 15 || bad != 0)
            $display("FAIL self_jump_fetch: got %0d fetches, %0d off-address want >=15, 0", fetch_q.size(), bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid_handshake();
        int k;
        clear_mem();
        imem[0] = 16'h4005;
        dmem_dly[0] = 1000;
        apply_reset();
        pulse_run();
        k = 0;
        while (!DMEM_REQ && k < 20) begin
            @(negedge CLK); k++;
        end
        #1;
        n_checks++;
        if (DMEM_REQ !== 1'b1 || IDEN !== 2'b01) $display("FAIL rst_mid_reach_read: got req=%b iden=%b want 1/01", DMEM_REQ, IDEN);
        else n_pass++;
        RST = 1'b1;
        mem_auto = 1'b0;
        DMEM_ACK = 1'b0;
        IMEM_ACK = 1'b0;
        @(negedge CLK); #1;
        n_checks++;
        if ({IMEM_REQ, DMEM_REQ, DMEM_WE, START, BUSY, HALTED} !== 6'b0 || PC !== 8'h00 ||
            IDEN !== 2'b00 || OPCODE !== 4'h0 || OPERAND !== 16'h0)
            $display("FAIL rst_mid_state: got strobes=%b pc=%h iden=%b opc=%h opnd=%h want all 0",
                     {IMEM_REQ, DMEM_REQ, DMEM_WE, START, BUSY, HALTED}, PC, IDEN, OPCODE, OPERAND);
        else n_pass++;
        RST = 1'b0;
        DMEM_ACK = 1'b1;
        DMEM_RDATA = 16'hFFFF;
        @(negedge CLK); #1;
        DMEM_ACK = 1'b0;
        @(negedge CLK); #1;
        n_checks++;
        if (DMEM_REQ !== 1'b0 || BUSY !== 1'b0 || OPERAND !== 16'h0 || START !== 1'b0)
            $display("FAIL rst_late_ack: got req=%b busy=%b opnd=%h start=%b want 0/0/0000/0", DMEM_REQ, BUSY, OPERAND, START);
        else n_pass++;
        mem_auto = 1'b1;
    endtask

    task automatic test_random();
        int len, r;
        logic [15:0] w;
        for (int it = 0; it < 8; it++) begin
            clear_mem();
            for (int k = 0; k < 64; k++) begin
                imem_dly[k] = $urandom_range(0, 3);
                dmem_dly[k] = $urandom_range(0, 3);
            end
            store_xor = 16'($urandom);
            len = $urandom_range(4, 14);
            for (int i = 0; i < len - 1; i++) begin
                w = 16'($urandom);
                case ($urandom_range(0, 4))
                    0: w[15:14] = 2'b00;
                    1: begin
                        r = $urandom_range(0, 6);
                        w[15:14] = 2'b01;
                        w[13:10] = (r < 6) ? 4'(r) : 4'd8;
                    end
                    2: begin
                        r = $urandom_range(0, 7);
                        w[15:14] = 2'b01;
                        w[13:10] = (r < 2) ? 4'(6 + r) : 4'(7 + r);
                    end
                    3: begin
                        w[15:14] = 2'b01;
                        w[13:10] = 4'hF;
                    end
                    default: begin
                        w[15:14] = 2'b10;
                        w[7:0] = 8'($urandom_range(i + 1, len - 1));
                    end
                endcase
                imem[i] = w;
            end
            run_program("random", 500);
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        RST = 1'b1; RUN = 1'b0; mem_auto = 1'b1;
        IMEM_ACK = 1'b0; DMEM_ACK = 1'b0; IMEM_RDATA = 16'h0; DMEM_RDATA = 16'h0;
        STORE_DATA = 16'h0; t0 = 0; halt_cyc = -1; hold_err = 0;
        imem_idx = 0; dmem_idx = 0; imem_cnt = 0; dmem_cnt = 0;
        test_reset();
        test_mem_operand();
        test_immediate();
        test_store();
        test_wait_states();
        test_jump_halt_restart();
        test_pc_wrap();
        test_self_jump();
        test_reset_mid_handshake();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
